// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/GPU) arbiter for a single-port synchronous memory.
// GPU has priority; a starvation counter bounds how long a waiting CPU can be held off.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int GPU_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_gnt,
  output logic              gpu_rvalid,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (GPU_BURST < 1) ? 1 : $clog2(GPU_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(GPU_BURST);

  logic             cpu_elig, gpu_elig;
  logic             cpu_win, gpu_win;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             rd_vld_p1, rd_gpu_p1;
  logic [DATA_W-1:0] cpu_rdata_hold, gpu_rdata_hold;

  // A requester in its acknowledge cycle is not eligible, which forces alternation under contention.
  always_comb begin
    cpu_elig   = cpu_req & ~cpu_gnt;
    gpu_elig   = gpu_req & ~gpu_gnt;
    gpu_win    = gpu_elig & ~(cpu_elig & (starve_cnt == BURST_MAX));
    cpu_win    = cpu_elig & ~gpu_win;
    starve_nxt = starve_cnt;
    if (!cpu_req || cpu_win)
      starve_nxt = '0;
    else if (gpu_win && (starve_cnt != BURST_MAX))
      starve_nxt = starve_cnt + CNT_W'(1);
  end

  // Stage p1: grant, memory command and read tag; stage p2: rvalid aligned with mem_rdata.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_gnt    <= 1'b0;
      gpu_gnt    <= 1'b0;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_vld_p1  <= 1'b0;
      rd_gpu_p1  <= 1'b0;
      cpu_rvalid <= 1'b0;
      gpu_rvalid <= 1'b0;
    end else begin
      cpu_gnt    <= cpu_win;
      gpu_gnt    <= gpu_win;
      starve_cnt <= starve_nxt;
      mem_we     <= 1'b0;
      if (gpu_win) begin
        mem_addr  <= gpu_addr;
        mem_wdata <= gpu_wdata;
        mem_we    <= gpu_we;
      end else if (cpu_win) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_we;
      end
      rd_vld_p1  <= (gpu_win & ~gpu_we) | (cpu_win & ~cpu_we);
      rd_gpu_p1  <= gpu_win;
      cpu_rvalid <= rd_vld_p1 & ~rd_gpu_p1;
      gpu_rvalid <= rd_vld_p1 & rd_gpu_p1;
    end
  end

  // Non-target rdata keeps the last word delivered to that requester.
  always_ff @(posedge clock) begin
    if (cpu_rvalid) cpu_rdata_hold <= mem_rdata;
    if (gpu_rvalid) gpu_rdata_hold <= mem_rdata;
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_hold;
  assign gpu_rdata = gpu_rvalid ? mem_rdata : gpu_rdata_hold;

endmodule
